multi_cycle_control_unit: RTL and testbench
===========================================

# multi_cycle_control_unit

Multi-cycle sequencer for the 32-bit CPU. It steps each instruction through IF/ID/EXE/MEM/WB and issues the per-cycle write enables and mux selects for these blocks: PC, instruction memory, IR, register file, ALU and data memory. It decodes the 6-bit opcode held in IR and the ALU zero flag, and counts retired instructions. It sits between the IR and the datapath, replacing the single-cycle combinational control.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; forces IF state
- opcode  in  6  IR[31:26]; ignored in IF, stable from ID onward
- zero  in  1  ALU zero flag, sampled in EXE_BR only
- PCWre  out  1  PC load enable (one pulse per retired instruction)
- InsMemRW  out  1  1 = instruction memory read (IF only)
- IRWre  out  1  IR load enable (IF only)
- ExtSel  out  1  0 = zero-extend imm16 (ORI), 1 = sign-extend
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data
- ALUOp  out  3  000 add, 001 sub, 011 or, 100 and
- PCSrc  out  2  00 PC+4, 01 PC+4+(sext(imm)<<2)
- RegDst  out  1  1 = rd, 0 = rt
- RegWre  out  1  register file write enable
- DBDataSrc  out  1  1 = data memory, 0 = ALU result
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse on undefined opcode in ID
- instr_count  out  CNT_W  retired instructions (PCWre pulses)

## Operation
- Opcodes: ADD 000000, SUB 000001, ORI 010000, AND 010001, OR 010010, MOVE 100000, SW 100110, LW 100111, BEQ 110000, HALT 111111; all others illegal.
- States and transitions:
  - IF → ID: IRWre=1, InsMemRW=1.
  - ID → EXE_AL for ADD, SUB, ORI, AND, OR and MOVE.
  - ID → EXE_BR for BEQ.
  - ID → EXE_LS for LW and SW.
  - ID → HALT for HALT.
  - ID → IF for an illegal opcode, with PCWre=1 and illegal=1; the instruction is retired as a NOP.
  - EXE_AL → WB_AL.
  - EXE_BR → IF: PCWre=1; PCSrc=01 if zero, else 00.
  - EXE_LS → MEM.
  - MEM, SW → IF: mWR=1, PCWre=1.
  - MEM, LW → WB_LD: mRD=1.
  - WB_AL → IF: RegWre=1, PCWre=1, DBDataSrc=0.
  - WB_LD → IF: RegWre=1, PCWre=1, DBDataSrc=1, mRD=1.
  - HALT: absorbing, all enables 0.
- Datapath selects are opcode-decoded and held constant from ID through the final state, glitch-free within each state:
  - ALUOp: ADD, MOVE, LW, SW → 000; SUB, BEQ → 001; ORI, OR → 011; AND → 100.
  - ALUSrcB=1 for ORI, LW and SW.
  - ExtSel=0 for ORI only.
  - RegDst=1 for ADD, SUB, AND, OR and MOVE; RegDst=0 for ORI and LW.
- All outputs are Moore-decoded from the state register plus opcode. The exception is PCSrc in EXE_BR, which also depends on zero.
- instr_count increments on every cycle with PCWre=1 and wraps silently at all-ones.

## Timing
- Reset (asynchronous) sets: state=IF, instr_count=0, halted=0, illegal=0, all enables 0.
  - IRWre and InsMemRW reassert combinationally as soon as state=IF.
- Reset mid-instruction: takes effect immediately, and no RegWre/mWR/PCWre is issued for the aborted instruction. On deassertion, the first rising edge leaves IF.
- Cycles per instruction, IF to the next IF:
  - ADD, SUB, ORI, AND, OR, MOVE: 4
  - BEQ: 3
  - SW: 4
  - LW: 5
  - illegal: 2
- Exactly one PCWre pulse per retired instruction, asserted in its last state, so the PC updates on the edge entering IF.
- RegWre, mWR and PCWre are never high outside the states listed above.
- HALT exits only through Reset.

## Structure
- Shared package cpu_defs holds:
  - the opcode localparams;
  - the ALUOp and PCSrc codes;
  - the state encoding: IF=000, ID=001, EXE_AL=110, EXE_BR=101, EXE_LS=010, MEM=011, WB_AL=111, WB_LD=100, HALT as a fourth bit or distinct code.
- One sub-module, ctrl_decode: purely combinational (state, opcode, zero) → next_state plus all control outputs.
- The top level holds the state register, the instr_count register and the illegal/halted registers.

## Test plan
- Reset pulse mid-WB_AL of an ADD → state=IF immediately, RegWre=0, instr_count=0; ADD not retired.
- Sequence ORI, ORI, ADD, SUB, AND, OR → 24 cycles, 6 PCWre pulses, instr_count=6. RegWre fires in cycle 4 of each instruction. ALUOp per instruction: 011, 011, 000, 001, 100, 011.
- BEQ with zero=1, then BEQ with zero=0 → 3 cycles each, PCSrc=01 then 00 in EXE_BR, RegWre never set.
- SW then LW → SW: mWR=1 in cycle 4 only. LW: mRD=1 in cycles 4–5, RegWre=1 and DBDataSrc=1 in cycle 5, ALUSrcB=1, ExtSel=1, RegDst=0.
- Opcode 101010 → illegal=1 for one cycle in ID, PCWre=1, back to IF after 2 cycles, instr_count increments.
- HALT → halted=1 after ID, all enables 0 for 100 cycles, instr_count frozen; Reset returns to IF with halted=0.

Source files
------------

// File: rtl/multi_cycle_control_unit_pkg.sv
// cpu_defs: opcodes, ALU/PC select codes and sequencer state encoding shared by the control unit.
package cpu_defs;
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ORI  = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_OR   = 6'b010010;
   localparam logic [5:0] OP_MOVE = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;

   // HALT sits on the fourth bit so the eight execution states keep their 3-bit codes.
   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_AL = 4'b0110,
      S_EXE_BR = 4'b0101,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_AL  = 4'b0111,
      S_WB_LD  = 4'b0100,
      S_HALT   = 4'b1000
   } state_t;
endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: opcode/flag inputs and control outputs between sequencer and datapath.
interface multi_cycle_control_unit_if #(parameter int CNT_W = 16);
   logic [5:0] opcode;
   logic zero;
   logic PCWre;
   logic InsMemRW;
   logic IRWre;
   logic ExtSel;
   logic ALUSrcB;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic RegDst;
   logic RegWre;
   logic DBDataSrc;
   logic mRD;
   logic mWR;
   logic halted;
   logic illegal;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input opcode, zero,
      output PCWre, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp, PCSrc, RegDst,
             RegWre, DBDataSrc, mRD, mWR, halted, illegal, instr_count
   );
   modport slave (
      output opcode, zero,
      input PCWre, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp, PCSrc, RegDst,
            RegWre, DBDataSrc, mRD, mWR, halted, illegal, instr_count
   );
endinterface

// File: rtl/multi_cycle_control_unit_ctrl_decode.sv
// ctrl_decode: combinational next-state and control decode from state, opcode and zero.
module ctrl_decode
   import cpu_defs::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   output state_t     nextState,
   output logic       PCWre,
   output logic       InsMemRW,
   output logic       IRWre,
   output logic       ExtSel,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       RegDst,
   output logic       RegWre,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic       illegal
);
   logic isAl, isLs, isLw, isKnown, selOn;

   assign isAl = opcode inside {OP_ADD, OP_SUB, OP_ORI, OP_AND, OP_OR, OP_MOVE};
   assign isLs = opcode inside {OP_SW, OP_LW};
   assign isLw = opcode == OP_LW;
   assign isKnown = isAl || isLs || opcode inside {OP_BEQ, OP_HALT};
   // Selects follow the opcode only once IR is valid, so they hold steady from ID to the last state.
   assign selOn = state != S_IF && state != S_HALT;

   assign ALUOp = !selOn ? ALU_ADD :
                  opcode inside {OP_SUB, OP_BEQ} ? ALU_SUB :
                  opcode inside {OP_ORI, OP_OR} ? ALU_OR :
                  opcode == OP_AND ? ALU_AND : ALU_ADD;
   assign ALUSrcB = selOn && opcode inside {OP_ORI, OP_LW, OP_SW};
   assign ExtSel = selOn && opcode != OP_ORI;
   assign RegDst = selOn && opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOVE};

   always_comb begin
      nextState = state;
      PCWre = 1'b0;
      InsMemRW = 1'b0;
      IRWre = 1'b0;
      PCSrc = PC_NEXT;
      RegWre = 1'b0;
      DBDataSrc = 1'b0;
      mRD = 1'b0;
      mWR = 1'b0;
      illegal = 1'b0;
      case (state)
         S_IF: begin
            InsMemRW = 1'b1;
            IRWre = 1'b1;
            nextState = S_ID;
         end
         S_ID: begin
            nextState = isAl ? S_EXE_AL : opcode == OP_BEQ ? S_EXE_BR :
                        isLs ? S_EXE_LS : opcode == OP_HALT ? S_HALT : S_IF;
            illegal = !isKnown;
            PCWre = !isKnown;
         end
         S_EXE_AL: nextState = S_WB_AL;
         S_EXE_BR: begin
            nextState = S_IF;
            PCWre = 1'b1;
            PCSrc = zero ? PC_BRANCH : PC_NEXT;
         end
         S_EXE_LS: nextState = S_MEM;
         S_MEM: begin
            nextState = isLw ? S_WB_LD : S_IF;
            mRD = isLw;
            mWR = !isLw;
            PCWre = !isLw;
         end
         S_WB_AL: begin
            nextState = S_IF;
            RegWre = 1'b1;
            PCWre = 1'b1;
         end
         S_WB_LD: begin
            nextState = S_IF;
            RegWre = 1'b1;
            PCWre = 1'b1;
            DBDataSrc = 1'b1;
            mRD = 1'b1;
         end
         S_HALT: nextState = S_HALT;
         default: nextState = S_IF;
      endcase
   end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EXE/MEM/WB sequencer with retired-instruction counter.
module multi_cycle_control_unit
   import cpu_defs::*;
#(
   parameter int CNT_W = 16
) (
   input logic CLK,
   input logic Reset,
   multi_cycle_control_unit_if.master bus
);
   state_t state, nextState;
   logic haltedQ;
   logic [CNT_W-1:0] count;

   ctrl_decode decode (
      .state(state),
      .opcode(bus.opcode),
      .zero(bus.zero),
      .nextState(nextState),
      .PCWre(bus.PCWre),
      .InsMemRW(bus.InsMemRW),
      .IRWre(bus.IRWre),
      .ExtSel(bus.ExtSel),
      .ALUSrcB(bus.ALUSrcB),
      .ALUOp(bus.ALUOp),
      .PCSrc(bus.PCSrc),
      .RegDst(bus.RegDst),
      .RegWre(bus.RegWre),
      .DBDataSrc(bus.DBDataSrc),
      .mRD(bus.mRD),
      .mWR(bus.mWR),
      .illegal(bus.illegal)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= S_IF;
         haltedQ <= 1'b0;
         count <= '0;
      end else begin
         state <= nextState;
         haltedQ <= nextState == S_HALT;
         count <= count + CNT_W'(bus.PCWre);
      end
   end

   assign bus.halted = haltedQ;
   assign bus.instr_count = count;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed instruction sequences checked cycle by cycle against a queued expectation.
module tb_multi_cycle_control_unit;
   import cpu_defs::*;

   typedef struct packed {
      logic PCWre, InsMemRW, IRWre, ExtSel, ALUSrcB;
      logic [2:0] ALUOp;
      logic [1:0] PCSrc;
      logic RegDst, RegWre, DBDataSrc, mRD, mWR, halted, illegal;
   } ctl_t;

   typedef struct {
      ctl_t exp;
      ctl_t mask;
      logic [5:0] op;
      logic z;
      int cyc;
   } ent_t;

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   int passN = 0;
   int failN = 0;
   int totalN = 0;
   int expCount = 0;
   ent_t q[$];

   multi_cycle_control_unit_if #(.CNT_W(16)) bus ();
   multi_cycle_control_unit #(.CNT_W(16)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   function automatic ctl_t observed();
      ctl_t g;
      g.PCWre = bus.PCWre;
      g.InsMemRW = bus.InsMemRW;
      g.IRWre = bus.IRWre;
      g.ExtSel = bus.ExtSel;
      g.ALUSrcB = bus.ALUSrcB;
      g.ALUOp = bus.ALUOp;
      g.PCSrc = bus.PCSrc;
      g.RegDst = bus.RegDst;
      g.RegWre = bus.RegWre;
      g.DBDataSrc = bus.DBDataSrc;
      g.mRD = bus.mRD;
      g.mWR = bus.mWR;
      g.halted = bus.halted;
      g.illegal = bus.illegal;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalN++;
      assert (got === exp) passN++;
      else begin
         failN++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit isReal(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ORI, OP_AND, OP_OR, OP_MOVE, OP_SW, OP_LW, OP_BEQ};
   endfunction

   // Don't-care fields are masked: selects outside a real instruction's ID..last state,
   // RegDst where no register is written, PCSrc/DBDataSrc where nothing consumes them.
   task automatic push(input logic [5:0] op, input logic z, input int cyc, input ctl_t e);
      ctl_t m;
      ent_t n;
      m = '1;
      if (cyc == 1 || !isReal(op)) begin
         m.ExtSel = 1'b0;
         m.ALUSrcB = 1'b0;
         m.ALUOp = 3'b000;
         m.RegDst = 1'b0;
      end else begin
         e.ALUOp = op inside {OP_SUB, OP_BEQ} ? 3'b001 : op inside {OP_ORI, OP_OR} ? 3'b011 :
                   op == OP_AND ? 3'b100 : 3'b000;
         e.ALUSrcB = op inside {OP_ORI, OP_LW, OP_SW};
         e.ExtSel = op != OP_ORI;
         e.RegDst = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOVE};
         if (op inside {OP_BEQ, OP_SW}) m.RegDst = 1'b0;
      end
      if (!e.PCWre) m.PCSrc = 2'b00;
      if (!e.RegWre) m.DBDataSrc = 1'b0;
      n.exp = e;
      n.mask = m;
      n.op = op;
      n.z = z;
      n.cyc = cyc;
      q.push_back(n);
   endtask

   task automatic pushInstr(input logic [5:0] op, input logic z);
      ctl_t e;
      e = '0;
      e.InsMemRW = 1'b1;
      e.IRWre = 1'b1;
      push(op, z, 1, e);
      e = '0;
      if (!(isReal(op) || op == OP_HALT)) begin
         e.PCWre = 1'b1;
         e.illegal = 1'b1;
         push(op, z, 2, e);
         return;
      end
      push(op, z, 2, e);
      if (op == OP_HALT) begin
         e.halted = 1'b1;
         for (int i = 0; i < 100; i++) push(op, z, 3 + i, e);
         return;
      end
      if (op == OP_BEQ) begin
         e.PCWre = 1'b1;
         e.PCSrc = z ? 2'b01 : 2'b00;
         push(op, z, 3, e);
         return;
      end
      push(op, z, 3, e);
      if (op == OP_SW) begin
         e.mWR = 1'b1;
         e.PCWre = 1'b1;
         push(op, z, 4, e);
         return;
      end
      if (op == OP_LW) begin
         e.mRD = 1'b1;
         push(op, z, 4, e);
         e.RegWre = 1'b1;
         e.PCWre = 1'b1;
         e.DBDataSrc = 1'b1;
         push(op, z, 5, e);
         return;
      end
      e.RegWre = 1'b1;
      e.PCWre = 1'b1;
      push(op, z, 4, e);
   endtask

   // Called at a falling edge with the DUT in IF; consumes one queue entry per cycle.
   task automatic drain();
      ent_t n;
      ctl_t g;
      while (q.size() > 0) begin
         n = q.pop_front();
         bus.opcode = n.op;
         bus.zero = n.z;
         #1;
         g = observed();
         chk($sformatf("ctl op=%b cyc=%0d", n.op, n.cyc), 32'(g & n.mask), 32'(n.exp & n.mask));
         chk($sformatf("cnt op=%b cyc=%0d", n.op, n.cyc), 32'(bus.instr_count), 32'(expCount));
         if (n.exp.PCWre) expCount = (expCount + 1) & 32'hffff;
         @(negedge CLK);
      end
   endtask

   initial begin
      bus.opcode = 6'b0;
      bus.zero = 1'b0;
      Reset = 1'b1;
      @(negedge CLK);
      chk("rst_IRWre", 32'(bus.IRWre), 32'd1);
      chk("rst_InsMemRW", 32'(bus.InsMemRW), 32'd1);
      chk("rst_PCWre", 32'(bus.PCWre), 32'd0);
      chk("rst_RegWre", 32'(bus.RegWre), 32'd0);
      chk("rst_mWR", 32'(bus.mWR), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_cnt", 32'(bus.instr_count), 32'd0);
      Reset = 1'b0;

      pushInstr(OP_ORI, 1'b0);
      pushInstr(OP_ORI, 1'b0);
      pushInstr(OP_ADD, 1'b0);
      pushInstr(OP_SUB, 1'b0);
      pushInstr(OP_AND, 1'b0);
      pushInstr(OP_OR, 1'b0);
      drain();
      chk("seq6_cnt", 32'(bus.instr_count), 32'd6);

      pushInstr(OP_BEQ, 1'b1);
      pushInstr(OP_BEQ, 1'b0);
      pushInstr(OP_SW, 1'b0);
      pushInstr(OP_LW, 1'b0);
      pushInstr(6'b101010, 1'b0);
      pushInstr(OP_MOVE, 1'b1);
      drain();
      chk("mix_cnt", 32'(bus.instr_count), 32'd12);

      pushInstr(OP_ADD, 1'b0);
      void'(q.pop_back());
      drain();
      chk("wbal_RegWre", 32'(bus.RegWre), 32'd1);
      Reset = 1'b1;
      #1;
      chk("abort_RegWre", 32'(bus.RegWre), 32'd0);
      chk("abort_PCWre", 32'(bus.PCWre), 32'd0);
      chk("abort_IRWre", 32'(bus.IRWre), 32'd1);
      chk("abort_cnt", 32'(bus.instr_count), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      expCount = 0;
      pushInstr(OP_ADD, 1'b0);
      drain();
      chk("post_abort_cnt", 32'(bus.instr_count), 32'd1);

      pushInstr(OP_HALT, 1'b0);
      drain();
      chk("halt_cnt", 32'(bus.instr_count), 32'd1);
      Reset = 1'b1;
      #1;
      chk("unhalt_halted", 32'(bus.halted), 32'd0);
      chk("unhalt_IRWre", 32'(bus.IRWre), 32'd1);
      chk("unhalt_cnt", 32'(bus.instr_count), 32'd0);
      @(negedge CLK);
      Reset = 1'b0;
      expCount = 0;
      pushInstr(OP_LW, 1'b0);
      drain();

      $display("%0d/%0d checks passed", passN, totalN);
      $finish;
   end
endmodule
